// File: rtl/d5m_cfg_pkg.sv
// Shared types and constants for the D5M power-up / configuration sequencer.
//   state_e     : top-level sequencer states
//   tbl_entry_t : one register-table entry {reg_addr, data}
package d5m_cfg_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RST_HOLD,
        ST_RST_WAIT,
        ST_FETCH,
        ST_START,
        ST_BYTE,
        ST_ACK,
        ST_STOP,
        ST_GAP,
        ST_DONE,
        ST_ERR
    } state_e;

    typedef struct packed {
        logic [7:0]  reg_addr;
        logic [15:0] data;
    } tbl_entry_t;

    // 8-bit sensor write address, R/W bit (0) included
    localparam logic [7:0] DEV_ADDR_DEF = 8'hBA;

    localparam int unsigned BYTE_TICKS  = 32;  // 8 bits x 4 ticks
    localparam int unsigned START_TICKS = 3;
    localparam int unsigned STOP_TICKS  = 3;
    localparam int unsigned GAP_TICKS   = 4;

endpackage

// File: rtl/d5m_i2c_byte_tx.sv
// Two-wire byte transmitter: shifts one byte MSB first, then runs the ACK slot.
// Each bit spans 4 ticks: SCL low (data set up), high, high, low.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   tick         : quarter-bit strobe
//   load         : start a new byte (issued on a tick boundary)
//   tx_byte      : byte to send
//   sda_in       : sampled SDA line level
//   scl, sda_oe  : bus levels for the current quarter-bit
//   ack_ok       : slave acknowledged the last byte
//   byte_done    : high during the final quarter of the ACK slot
module d5m_i2c_byte_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       load,
    input  logic [7:0] tx_byte,
    input  logic       sda_in,
    output logic       scl,
    output logic       sda_oe,
    output logic       ack_ok,
    output logic       byte_done
);

    localparam int unsigned BIT_W = 4;
    localparam logic [BIT_W-1:0] ACK_BIT = BIT_W'(8);

    logic [7:0]       shift_q, shift_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [1:0]       ph_q, ph_d;
    logic             active_q, active_d;
    logic             scl_q, scl_d;
    logic             sda_oe_q, sda_oe_d;
    logic             ack_ok_q, ack_ok_d;
    logic             byte_done_q, byte_done_d;

    // Quarter-bit sequencing; bit index 8 is the ACK slot
    always_comb begin
        shift_d     = shift_q;
        bit_d       = bit_q;
        ph_d        = ph_q;
        active_d    = active_q;
        scl_d       = scl_q;
        sda_oe_d    = sda_oe_q;
        ack_ok_d    = ack_ok_q;
        byte_done_d = byte_done_q;

        if (load) begin
            shift_d     = tx_byte;
            bit_d       = '0;
            ph_d        = 2'd0;
            active_d    = 1'b1;
            scl_d       = 1'b0;
            sda_oe_d    = ~tx_byte[7];
            ack_ok_d    = 1'b0;
            byte_done_d = 1'b0;
        end else if (tick && active_q) begin
            ph_d = ph_q + 2'd1;
            case (ph_q)
                2'd0: scl_d = 1'b1;
                2'd1: scl_d = 1'b1;
                2'd2: begin
                    scl_d = 1'b0;
                    // End of the second high quarter: slave ACK is stable
                    if (bit_q == ACK_BIT) begin
                        ack_ok_d    = ~sda_in;
                        byte_done_d = 1'b1;
                    end
                end
                default: begin
                    byte_done_d = 1'b0;
                    if (bit_q == ACK_BIT) begin
                        active_d = 1'b0;
                    end else begin
                        bit_d    = bit_q + BIT_W'(1);
                        shift_d  = {shift_q[6:0], 1'b0};
                        // After the LSB, release SDA for the ACK slot
                        sda_oe_d = (bit_q == BIT_W'(7)) ? 1'b0 : ~shift_q[6];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q     <= '0;
            bit_q       <= '0;
            ph_q        <= 2'd0;
            active_q    <= 1'b0;
            scl_q       <= 1'b1;
            sda_oe_q    <= 1'b0;
            ack_ok_q    <= 1'b0;
            byte_done_q <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            bit_q       <= bit_d;
            ph_q        <= ph_d;
            active_q    <= active_d;
            scl_q       <= scl_d;
            sda_oe_q    <= sda_oe_d;
            ack_ok_q    <= ack_ok_d;
            byte_done_q <= byte_done_d;
        end
    end

    assign scl       = scl_q;
    assign sda_oe    = sda_oe_q;
    assign ack_ok    = ack_ok_q;
    assign byte_done = byte_done_q;

endmodule

// File: rtl/d5m_config_ctrl.sv
// TRDB_D5M power-up and configuration sequencer.
// On ul1Start: pulse sensor reset, wait to settle, then write TABLE_LEN entries
// from an external ROM to the sensor as {DEV_ADDR, reg_addr, data_hi, data_lo}.
// Ports:
//   ul1Clock, ul1Reset      : clock, synchronous active-high reset
//   ul1Start                : start pulse (accepted in IDLE/DONE/ERR)
//   ul8TableAddr / ul24TableData : ROM address out, entry in (1 clock latency)
//   ul1SensorResetn         : sensor reset, active low
//   ul1SclOut, ul1SdaOe, ul1SdaIn : two-wire bus (SDA open drain)
//   ul1Busy, ul1Done, ul1Error, ul8ErrIndex : status
module d5m_config_ctrl
    import d5m_cfg_pkg::*;
#(
    parameter int unsigned CLK_DIV       = 125,
    parameter int unsigned TABLE_LEN     = 16,
    parameter int unsigned RESET_CYCLES  = 1000,
    parameter int unsigned SETTLE_CYCLES = 2000,
    parameter logic [7:0]  DEV_ADDR      = DEV_ADDR_DEF
) (
    input  logic        ul1Clock,
    input  logic        ul1Reset,
    input  logic        ul1Start,
    output logic [7:0]  ul8TableAddr,
    input  logic [23:0] ul24TableData,
    output logic        ul1SensorResetn,
    output logic        ul1SclOut,
    output logic        ul1SdaOe,
    input  logic        ul1SdaIn,
    output logic        ul1Busy,
    output logic        ul1Done,
    output logic        ul1Error,
    output logic [7:0]  ul8ErrIndex
);

    localparam int unsigned DIV_W    = $clog2(CLK_DIV);
    localparam int unsigned HOLD_MAX = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_MAX  = (HOLD_MAX > BYTE_TICKS) ? HOLD_MAX : BYTE_TICKS;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       idx_q, idx_d;
    logic [1:0]       byte_sel_q, byte_sel_d;
    logic             nack_q, nack_d;
    tbl_entry_t       entry_q, entry_d;
    logic [7:0]       addr_q, addr_d;
    logic             resetn_q, resetn_d;
    logic             scl_q, scl_d;
    logic             sda_oe_q, sda_oe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [7:0]       err_idx_q, err_idx_d;

    logic             bus_st;
    logic             tick;
    logic             load;
    logic [7:0]       tx_byte;
    logic             tx_scl;
    logic             tx_sda_oe;
    logic             tx_ack_ok;
    logic             tx_byte_done;

    // Quarter-SCL strobe; divider idles at 0 outside the bus states
    always_comb begin
        bus_st = (state_q == ST_START) || (state_q == ST_BYTE) || (state_q == ST_ACK) ||
                 (state_q == ST_STOP)  || (state_q == ST_GAP);
        tick   = bus_st && (div_q == DIV_W'(CLK_DIV - 1));
    end

    d5m_i2c_byte_tx u_byte_tx (
        .clk       (ul1Clock),
        .rst       (ul1Reset),
        .tick      (tick),
        .load      (load),
        .tx_byte   (tx_byte),
        .sda_in    (ul1SdaIn),
        .scl       (tx_scl),
        .sda_oe    (tx_sda_oe),
        .ack_ok    (tx_ack_ok),
        .byte_done (tx_byte_done)
    );

    // Next-state, sequencing and bus levels
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        byte_sel_d = byte_sel_q;
        nack_d     = nack_q;
        entry_d    = entry_q;
        addr_d     = addr_q;
        resetn_d   = resetn_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        err_idx_d  = err_idx_q;
        load       = 1'b0;
        tx_byte    = DEV_ADDR;
        div_d      = '0;
        if (bus_st) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
        end

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (ul1Start) begin
                    state_d  = ST_RST_HOLD;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                    idx_d    = '0;
                    cnt_d    = '0;
                    resetn_d = 1'b0;
                end
            end
            ST_RST_HOLD: begin
                if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
                    cnt_d    = '0;
                    resetn_d = 1'b1;
                    state_d  = ST_RST_WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RST_WAIT: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (TABLE_LEN > 0) begin
                        state_d = ST_FETCH;
                        addr_d  = idx_q;
                    end else begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FETCH: begin
                // Address presented on entry; ROM data valid one clock later
                if (cnt_q == CNT_W'(1)) begin
                    entry_d    = tbl_entry_t'(ul24TableData);
                    cnt_d      = '0;
                    byte_sel_d = 2'd0;
                    nack_d     = 1'b0;
                    state_d    = ST_START;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_START: begin
                if (tick) begin
                    if (cnt_q == CNT_W'(START_TICKS - 1)) begin
                        cnt_d   = '0;
                        load    = 1'b1;
                        state_d = ST_BYTE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_BYTE: begin
                if (tick) begin
                    if (cnt_q == CNT_W'(BYTE_TICKS - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_ACK;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_ACK: begin
                if (tick && tx_byte_done) begin
                    cnt_d = '0;
                    if (!tx_ack_ok) begin
                        nack_d  = 1'b1;
                        state_d = ST_STOP;
                    end else if (byte_sel_q == 2'd3) begin
                        state_d = ST_STOP;
                    end else begin
                        byte_sel_d = byte_sel_q + 2'd1;
                        load       = 1'b1;
                        state_d    = ST_BYTE;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (cnt_q == CNT_W'(STOP_TICKS - 1)) begin
                        cnt_d = '0;
                        if (nack_q) begin
                            state_d   = ST_ERR;
                            busy_d    = 1'b0;
                            err_d     = 1'b1;
                            err_idx_d = idx_q;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (cnt_q == CNT_W'(GAP_TICKS - 1)) begin
                        cnt_d = '0;
                        idx_d = idx_q + 8'd1;
                        if (({1'b0, idx_q} + 9'd1) < 9'(TABLE_LEN)) begin
                            state_d = ST_FETCH;
                            addr_d  = idx_q + 8'd1;
                        end else begin
                            state_d = ST_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case (byte_sel_d)
            2'd0:    tx_byte = DEV_ADDR;
            2'd1:    tx_byte = entry_q.reg_addr;
            2'd2:    tx_byte = entry_q.data[15:8];
            default: tx_byte = entry_q.data[7:0];
        endcase

        // Bus levels follow the current quarter; registered, so every source lags one clock alike
        if ((state_q == ST_BYTE) || (state_q == ST_ACK)) begin
            scl_d    = tx_scl;
            sda_oe_d = tx_sda_oe;
        end else if (state_q == ST_START) begin
            // idle, SDA falls under SCL high, SCL falls
            scl_d    = (cnt_q != CNT_W'(2));
            sda_oe_d = (cnt_q != CNT_W'(0));
        end else if (state_q == ST_STOP) begin
            // SCL low/SDA low, SCL rises, SDA released
            scl_d    = (cnt_q != CNT_W'(0));
            sda_oe_d = (cnt_q != CNT_W'(2));
        end else begin
            scl_d    = 1'b1;
            sda_oe_d = 1'b0;
        end
    end

    always_ff @(posedge ul1Clock) begin
        if (ul1Reset) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            byte_sel_q <= 2'd0;
            nack_q     <= 1'b0;
            entry_q    <= '0;
            addr_q     <= '0;
            resetn_q   <= 1'b1;
            scl_q      <= 1'b1;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            byte_sel_q <= byte_sel_d;
            nack_q     <= nack_d;
            entry_q    <= entry_d;
            addr_q     <= addr_d;
            resetn_q   <= resetn_d;
            scl_q      <= scl_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_idx_q  <= err_idx_d;
        end
    end

    assign ul8TableAddr    = addr_q;
    assign ul1SensorResetn = resetn_q;
    assign ul1SclOut       = scl_q;
    assign ul1SdaOe        = sda_oe_q;
    assign ul1Busy         = busy_q;
    assign ul1Done         = done_q;
    assign ul1Error        = err_q;
    assign ul8ErrIndex     = err_idx_q;

endmodule

// File: tb/tb_d5m_config_ctrl.sv
// Bench for d5m_config_ctrl: two-entry table with a decoding/ACKing slave model,
// plus a zero-length-table instance.
module tb_d5m_config_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start0 = 1'b0;

    logic [7:0]  table_addr;
    logic [23:0] rom_q = '0;
    logic        sensor_resetn, scl, sda_oe, sda_in, busy, done, error;
    logic [7:0]  err_idx;

    logic [7:0]  table_addr0;
    logic        sensor_resetn0, scl0, sda_oe0, busy0, done0, error0;
    logic [7:0]  err_idx0;

    always #5 clk = ~clk;

    d5m_config_ctrl #(
        .CLK_DIV(4), .TABLE_LEN(2), .RESET_CYCLES(10), .SETTLE_CYCLES(20), .DEV_ADDR(8'hBA)
    ) dut (
        .ul1Clock(clk), .ul1Reset(rst), .ul1Start(start),
        .ul8TableAddr(table_addr), .ul24TableData(rom_q),
        .ul1SensorResetn(sensor_resetn), .ul1SclOut(scl), .ul1SdaOe(sda_oe), .ul1SdaIn(sda_in),
        .ul1Busy(busy), .ul1Done(done), .ul1Error(error), .ul8ErrIndex(err_idx)
    );

    d5m_config_ctrl #(
        .CLK_DIV(4), .TABLE_LEN(0), .RESET_CYCLES(10), .SETTLE_CYCLES(20), .DEV_ADDR(8'hBA)
    ) dut0 (
        .ul1Clock(clk), .ul1Reset(rst), .ul1Start(start0),
        .ul8TableAddr(table_addr0), .ul24TableData(24'h000000),
        .ul1SensorResetn(sensor_resetn0), .ul1SclOut(scl0), .ul1SdaOe(sda_oe0), .ul1SdaIn(1'b1),
        .ul1Busy(busy0), .ul1Done(done0), .ul1Error(error0), .ul8ErrIndex(err_idx0)
    );

    // Registered ROM, one clock of read latency
    always @(posedge clk) begin
        case (table_addr)
            8'd0:    rom_q <= 24'h200003;
            8'd1:    rom_q <= 24'h090500;
            default: rom_q <= 24'h000000;
        endcase
    end

    // Slave model state
    logic       slave_oe = 1'b0;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic       hi_seen = 1'b0;
    logic [7:0] shreg = '0;
    logic [7:0] cap [32];
    int         cap_n = 0;
    int         bitcnt = 0;
    int         pulses = 0;
    int         n_start = 0;
    int         n_stop = 0;
    int         nack_at = -1;
    int         scl0_lows = 0;

    assign sda_in = ~(sda_oe | slave_oe);

    // Bus decoder + ACK responder; a pulse is a complete SCL rise/fall between START and STOP
    always @(negedge clk) begin
        logic s_scl, s_sda;
        s_scl = scl;
        s_sda = sda_in;
        if (rst) begin
            slave_oe = 1'b0;
            hi_seen  = 1'b0;
            bitcnt   = 0;
            pulses   = 0;
            n_start  = 0;
            n_stop   = 0;
            cap_n    = 0;
        end else if (prev_scl && s_scl && prev_sda && !s_sda) begin
            n_start++;
            bitcnt  = 0;
            hi_seen = 1'b0;
        end else if (prev_scl && s_scl && !prev_sda && s_sda) begin
            n_stop++;
            bitcnt  = 0;
            hi_seen = 1'b0;
        end else if (!prev_scl && s_scl) begin
            hi_seen = 1'b1;
            if (bitcnt < 8) begin
                shreg = {shreg[6:0], s_sda};
                bitcnt++;
                if (bitcnt == 8 && cap_n < 32) begin
                    cap[cap_n] = shreg;
                    cap_n++;
                end
            end else if (bitcnt == 8) begin
                bitcnt = 9;
            end
        end else if (prev_scl && !s_scl) begin
            if (hi_seen) pulses++;
            hi_seen = 1'b0;
            if (bitcnt == 8) begin
                slave_oe = ((cap_n - 1) != nack_at);
            end else if (bitcnt == 9) begin
                slave_oe = 1'b0;
                bitcnt   = 0;
            end
        end
        prev_scl = s_scl;
        prev_sda = sda_in;
    end

    always @(negedge clk) begin
        if (rst) scl0_lows = 0;
        else if (!scl0) scl0_lows++;
    end

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_b [8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Start pulse, then measure the sensor-reset low time
    task automatic kick(input string tag);
        int n;
        n = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        while (!sensor_resetn && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_rst_low"}, 32'(n), 32'd10);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 5000) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_timeout"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_pulses(input string tag, input int target);
        int n;
        n = 0;
        while (pulses < target && n < 5000) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_reach"}, 32'(pulses >= target), 32'd1);
    endtask

    task automatic check_bytes(input string tag, input int base);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_byte%0d", tag, i), 32'(cap[base + i]), 32'(exp_b[i]));
        end
    endtask

    initial begin
        exp_b = '{8'hBA, 8'h20, 8'h00, 8'h03, 8'hBA, 8'h09, 8'h05, 8'h00};
        for (int i = 0; i < 32; i++) cap[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_resetn", 32'(sensor_resetn), 32'd1);
        check("rst_scl",    32'(scl),           32'd1);
        check("rst_sdaoe",  32'(sda_oe),        32'd0);
        check("rst_busy",   32'(busy),          32'd0);
        check("rst_done",   32'(done),          32'd0);
        check("rst_error",  32'(error),         32'd0);
        check("rst_erridx", 32'(err_idx),       32'd0);
        check("rst_addr",   32'(table_addr),    32'd0);

        // Nominal two-entry sequence
        kick("nom");
        wait_idle("nom");
        check("nom_done",   32'(done),  32'd1);
        check("nom_error",  32'(error), 32'd0);
        check("nom_pulses", 32'(pulses), 32'd72);
        check("nom_nbytes", 32'(cap_n),  32'd8);
        check("nom_starts", 32'(n_start), 32'd2);
        check("nom_stops",  32'(n_stop),  32'd2);
        check("nom_addr",   32'(table_addr), 32'd1);
        check_bytes("nom", 0);

        // NACK on data LSB of entry 1
        do_reset();
        nack_at = 7;
        kick("nack");
        wait_idle("nack");
        check("nack_error",  32'(error),   32'd1);
        check("nack_erridx", 32'(err_idx), 32'd1);
        check("nack_done",   32'(done),    32'd0);
        check("nack_pulses", 32'(pulses),  32'd72);
        check("nack_stops",  32'(n_stop),  32'd2);
        repeat (200) @(negedge clk);
        check("nack_quiet",  32'(pulses),  32'd72);
        check("nack_scl",    32'(scl),     32'd1);
        nack_at = -1;

        // Zero-length table: done after 10 + 20 clocks, no bus activity
        do_reset();
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        repeat (29) @(negedge clk);
        check("len0_done_early", 32'(done0), 32'd0);
        @(negedge clk);
        check("len0_done",  32'(done0), 32'd1);
        check("len0_busy",  32'(busy0), 32'd0);
        check("len0_scl",   32'(scl0_lows), 32'd0);

        // Reset mid-byte of entry 0, then restart
        do_reset();
        kick("mid");
        wait_pulses("mid", 5);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        check("mid_scl",    32'(scl),           32'd1);
        check("mid_sdaoe",  32'(sda_oe),        32'd0);
        check("mid_busy",   32'(busy),          32'd0);
        check("mid_resetn", 32'(sensor_resetn), 32'd1);
        @(negedge clk) rst = 1'b0;
        kick("restart");
        wait_idle("restart");
        check("restart_done",   32'(done),   32'd1);
        check("restart_pulses", 32'(pulses), 32'd72);
        check_bytes("restart", 0);

        // Start during BYTE is ignored; start after DONE repeats the sequence
        do_reset();
        kick("ign");
        wait_pulses("ign", 12);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("ign_busy", 32'(busy), 32'd1);
        wait_idle("ign");
        check("ign_done",   32'(done),   32'd1);
        check("ign_pulses", 32'(pulses), 32'd72);
        check("ign_nbytes", 32'(cap_n),  32'd8);
        check_bytes("ign", 0);
        kick("rep");
        check("rep_done_clr", 32'(done), 32'd0);
        wait_idle("rep");
        check("rep_done",   32'(done),   32'd1);
        check("rep_pulses", 32'(pulses), 32'd144);
        check("rep_nbytes", 32'(cap_n),  32'd16);
        check_bytes("rep", 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/d5m_config_ctrl.md
Name: d5m_config_ctrl

Overview:
- Power-up and configuration sequencer for the TRDB_D5M camera daughter board.
- On ul1Start it performs the following in order:
  - drives the sensor reset (ul1Resetn) low, then releases it;
  - waits a settle time;
  - writes a register table to the sensor over the board's two-wire serial bus (ul1Scl / ul1Sda).
- Sits between the top-level camera control logic and the driver side of the board interface.
- The register table lives in an external ROM and is read one entry at a time.

Parameters:
- CLK_DIV, 125: system clocks per quarter SCL period (50 MHz → 100 kHz SCL); legal range 2..1023.
- TABLE_LEN, 16: number of table entries to write; legal range 0..255.
- RESET_CYCLES, 1000: clocks ul1SensorResetn is held low.
- SETTLE_CYCLES, 2000: clocks to wait after reset release before the first transfer.
- DEV_ADDR, 8'hBA: 8-bit sensor write address (R/W bit = 0 included).

Ports:
- ul1Clock  in  1  system clock.
- ul1Reset  in  1  synchronous, active-high reset.
- ul1Start  in  1  single-cycle pulse; starts a sequence. Honoured only in IDLE, DONE or ERR.
- ul8TableAddr  out  8  ROM address of the entry being fetched.
- ul24TableData  in  24  ROM entry: {reg_addr[7:0], data[15:0]}. Valid 1 clock after ul8TableAddr changes.
- ul1SensorResetn  out  1  sensor reset, active low.
- ul1SclOut  out  1  SCL level (push-pull).
- ul1SdaOe  out  1  1 = pull SDA low; 0 = release (open drain).
- ul1SdaIn  in  1  sampled SDA line level.
- ul1Busy  out  1  sequence in progress.
- ul1Done  out  1  last sequence completed without error; sticky until the next start or reset.
- ul1Error  out  1  last sequence aborted on NACK; sticky until the next start or reset.
- ul8ErrIndex  out  8  table index of the failing entry; valid when ul1Error = 1.

Behaviour:
- Single clock domain, fully synchronous. Synchronous reset applies on the clock edge.
- Reset values:
  - ul1SensorResetn = 1, ul1SclOut = 1, ul1SdaOe = 0;
  - ul1Busy = 0, ul1Done = 0, ul1Error = 0;
  - ul8ErrIndex = 0, ul8TableAddr = 0; state = IDLE.
- A tick strobe fires every CLK_DIV clocks while in the bus states. The divider restarts at 0 on entry to START.
- States and transitions:
  - IDLE/DONE/ERR --ul1Start--> RST_HOLD. On this transition: ul1Busy = 1, ul1Done = 0, ul1Error = 0, index = 0.
  - RST_HOLD: ul1SensorResetn = 0 for exactly RESET_CYCLES clocks → RST_WAIT.
  - RST_WAIT: SETTLE_CYCLES clocks. Then → FETCH if TABLE_LEN > 0, else → DONE.
  - FETCH: ul8TableAddr = index; entry is latched 2 clocks later → START.
  - START: SDA falls while SCL is high. Then 4 bytes are sent in order: DEV_ADDR, reg_addr, data[15:8], data[7:0].
  - BYTE: 8 bits, MSB first, 4 ticks per bit:
    - tick0: SCL = 0, SDA = bit;
    - tick1–2: SCL = 1;
    - tick3: SCL = 0.
  - ACK: SDA released for one 4-tick bit. ul1SdaIn is sampled at the end of tick2.
    - 0 → next byte, or STOP after byte 4.
    - 1 → STOP, then ERR.
  - STOP: SCL rises with SDA low, then SDA is released. Sequence: 1 tick SCL low/SDA low, 1 tick SCL high, 1 tick SDA release.
  - GAP: 4 ticks bus idle. index++. Then → FETCH if index < TABLE_LEN, else → DONE.
  - DONE: ul1Busy = 0, ul1Done = 1.
  - ERR: ul1Busy = 0, ul1Error = 1, ul8ErrIndex = failing index.
- Each entry produces exactly 36 SCL high pulses. ul1SclOut and ul1SdaOe change only on tick boundaries.
- Boundary conditions:
  - ul1Start while ul1Busy = 1: ignored.
  - ul1Reset mid-transfer: next clock all outputs return to reset values. SCL/SDA are released with no STOP; the bus glitch is accepted.
  - index is 8 bits wide; index = TABLE_LEN-1 (255 max) is the last entry written. No wrap-around.
  - A NACK on any of the 4 bytes aborts the sequence. No retry.
  - ul1Start on the same clock as ul1Reset: reset wins.

Decomposition:
- Shared package d5m_cfg_pkg contains:
  - state enum (IDLE, RST_HOLD, RST_WAIT, FETCH, START, BYTE, ACK, STOP, GAP, DONE, ERR);
  - table-entry typedef (packed struct: reg_addr 8 bits, data 16 bits);
  - default constant DEV_ADDR = 8'hBA.
- One sub-module, d5m_i2c_byte_tx, handles:
  - 8-bit shift plus ACK slot;
  - inputs: tick, load, byte;
  - outputs: scl, sda_oe, ack_ok, byte_done.
- The top-level FSM handles START/STOP/GAP and table sequencing.

Test Plan:
- Configuration for all scenarios: CLK_DIV = 4, RESET_CYCLES = 10, SETTLE_CYCLES = 20, TABLE_LEN = 2, ROM = {24'h20_0003, 24'h09_0500}, slave model always ACKs.
- Nominal: ul1Start pulse → ul1SensorResetn low for exactly 10 clocks. Decoded bus bytes are BA 20 00 03, then BA 09 05 00. 72 SCL pulses total. Then ul1Done = 1, ul1Busy = 0.
- NACK: slave NACKs the data-LSB byte of entry 1 → STOP is issued, ul1Error = 1, ul8ErrIndex = 1, ul1Done = 0. No further SCL activity.
- TABLE_LEN = 0 → after 10 reset + 20 settle clocks: ul1Done = 1, zero SCL pulses.
- ul1Reset asserted mid-byte in entry 0 → next clock: SCL = 1, SdaOe = 0, Busy = 0, SensorResetn = 1. A new ul1Start restarts from RST_HOLD with index 0.
- ul1Start pulsed during BYTE → ignored: byte stream unchanged, exactly 72 SCL pulses. ul1Start after DONE → full sequence repeats and ul1Done is cleared during it.
